// File: rtl/spi_master_port.sv
// rtl/spi_master_port.sv - 16-bit SPI frame master; optional MISO synchronizer via SPI_MASTER_MISO_SYNC_EN
module spi_master_port #(
    parameter int HALF_PERIOD = 16,
    parameter int CS_SETUP    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk_pin,
    output logic       cs_pin,
    output logic       mosi_pin,
    input  logic       miso_pin
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam logic [7:0] HALF_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [4:0] LAST_BIT   = 5'd15;

    state_t      state;
    logic [7:0]  cnt;
    logic [4:0]  bit_cnt;
    logic        high_phase;
    logic [15:0] frame;
    logic [7:0]  rx_shift;
    logic        rw_q;
    logic        miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync;

    // Two-flop synchronizer; its latency is hidden inside the half period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miso_sync <= 2'b00;
        end else begin
            miso_sync <= {miso_sync[0], miso_pin};
        end
    end

    assign miso_s = miso_sync[1];
`else
    assign miso_s = miso_pin;
`endif

    // Frame sequencer: every pin and status output is a register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            bit_cnt    <= 5'd0;
            high_phase <= 1'b0;
            frame      <= 16'd0;
            rx_shift   <= 8'd0;
            rw_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 8'd0;
            sclk_pin   <= 1'b0;
            cs_pin     <= 1'b1;
            mosi_pin   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Read frames send zeros in the data byte
                        frame    <= {addr, rw, (rw ? 8'h00 : wdata)};
                        rw_q     <= rw;
                        mosi_pin <= addr[6];
                        cs_pin   <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= 8'd0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    mosi_pin <= frame[15];
                    if (cnt == SETUP_LAST) begin
                        cnt        <= 8'd0;
                        bit_cnt    <= 5'd0;
                        high_phase <= 1'b0;
                        state      <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + 8'd1;
                    end else if (!high_phase) begin
                        cnt        <= 8'd0;
                        high_phase <= 1'b1;
                        sclk_pin   <= 1'b1;
                    end else begin
                        // Falling edge: capture MISO, then either start the next low phase or finish
                        cnt        <= 8'd0;
                        high_phase <= 1'b0;
                        sclk_pin   <= 1'b0;
                        rx_shift   <= {rx_shift[6:0], miso_s};
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_HOLD;
                        end else begin
                            bit_cnt  <= bit_cnt + 5'd1;
                            frame    <= {frame[14:0], 1'b0};
                            mosi_pin <= frame[14];
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt == SETUP_LAST) begin
                        cnt      <= 8'd0;
                        cs_pin   <= 1'b1;
                        mosi_pin <= 1'b0;
                        done     <= 1'b1;
                        if (rw_q) begin
                            rdata <= rx_shift;
                        end
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= 8'd0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    cs_pin   <= 1'b1;
                    sclk_pin <= 1'b0;
                    mosi_pin <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_port.sv
// tb/tb_spi_master_port.sv - scoreboard bench for spi_master_port at default and fast timing
module tb_spi_master_port;

    localparam int H0 = 16;
    localparam int S0 = 16;
    localparam int H1 = 4;
    localparam int S1 = 4;

    typedef struct packed {
        logic [15:0] frame;
        logic [7:0]  rdata;
        int          acc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start_a [2];
    logic [6:0] addr_a  [2];
    logic       rw_a    [2];
    logic [7:0] wdata_a [2];
    logic       busy_a  [2];
    logic       done_a  [2];
    logic [7:0] rdata_a [2];
    logic       sclk_a  [2];
    logic       cs_a    [2];
    logic       mosi_a  [2];
    logic       miso_a  [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] ref_mem [2][128];
    logic [7:0] smem    [2][128];
    logic [7:0] last_rd [2];
    int         last_acc[2];

    int          bitcnt     [2];
    int          rises      [2];
    int          first_rise [2];
    int          cs_rise_cyc[2];
    bit          seen_rise  [2];
    logic [15:0] sh         [2];
    logic [7:0]  sout       [2];
    logic        srw        [2];
    logic [6:0]  saddr      [2];
    logic        psclk      [2];
    logic        pcs        [2];

    spi_master_port dut_slow (
        .clk(clk), .reset(reset), .start(start_a[0]), .addr(addr_a[0]), .rw(rw_a[0]),
        .wdata(wdata_a[0]), .busy(busy_a[0]), .done(done_a[0]), .rdata(rdata_a[0]),
        .sclk_pin(sclk_a[0]), .cs_pin(cs_a[0]), .mosi_pin(mosi_a[0]), .miso_pin(miso_a[0])
    );

    spi_master_port #(.HALF_PERIOD(H1), .CS_SETUP(S1)) dut_fast (
        .clk(clk), .reset(reset), .start(start_a[1]), .addr(addr_a[1]), .rw(rw_a[1]),
        .wdata(wdata_a[1]), .busy(busy_a[1]), .done(done_a[1]), .rdata(rdata_a[1]),
        .sclk_pin(sclk_a[1]), .cs_pin(cs_a[1]), .mosi_pin(mosi_a[1]), .miso_pin(miso_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hp(input int g);
        return (g == 0) ? H0 : H1;
    endfunction

    function automatic int sp(input int g);
        return (g == 0) ? S0 : S1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Stimulus: drive one request at a negedge where busy is low, push its expectation
    task automatic issue(input int g, input logic [6:0] a, input logic r, input logic [7:0] d);
        exp_t e;
        chk("busy_before_issue", 32'(busy_a[g]), 0);
        start_a[g] = 1'b1;
        addr_a[g]  = a;
        rw_a[g]    = r;
        wdata_a[g] = d;
        e.frame = {a, r, (r ? 8'h00 : d)};
        e.acc   = cyc;
        if (r) begin
            e.rdata    = ref_mem[g][a];
            last_rd[g] = e.rdata;
        end else begin
            ref_mem[g][a] = d;
            e.rdata       = last_rd[g];
        end
        if (g == 0) q0.push_back(e);
        else q1.push_back(e);
        last_acc[g] = cyc;
        @(negedge clk);
        start_a[g] = 1'b0;
        addr_a[g]  = 7'($urandom);
        rw_a[g]    = 1'($urandom);
        wdata_a[g] = 8'($urandom);
        chk("busy_cycle1", 32'(busy_a[g]), 1);
        chk("cs_low_cycle1", 32'(cs_a[g]), 0);
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (busy_a[g] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_fall_time", 32'(cyc - last_acc[g]), 32'(1 + 3 * sp(g) + 32 * hp(g)));
    endtask

    // SPI memory model plus done monitor; the monitor runs first so the captured frame is intact
    initial begin
        for (int g = 0; g < 2; g++) begin
            bitcnt[g] = 0; rises[g] = 0; first_rise[g] = 0; cs_rise_cyc[g] = 0;
            seen_rise[g] = 1'b0; sh[g] = 16'd0; sout[g] = 8'd0; srw[g] = 1'b0;
            saddr[g] = 7'd0; psclk[g] = 1'b0; pcs[g] = 1'b1; miso_a[g] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (done_a[g] === 1'b1) begin
                    exp_t e;
                    bit   have;
                    e = '0;
                    if (g == 0) begin
                        have = (q0.size() != 0);
                        if (have) e = q0.pop_front();
                    end else begin
                        have = (q1.size() != 0);
                        if (have) e = q1.pop_front();
                    end
                    chk("done_expected", 32'(have), 1);
                    if (have) begin
                        chk("done_time", 32'(cyc - e.acc), 32'(1 + 2 * sp(g) + 32 * hp(g)));
                        chk("first_rise_time", 32'(first_rise[g] - e.acc), 32'(1 + sp(g) + hp(g)));
                        chk("mosi_frame", 32'(sh[g]), 32'(e.frame));
                        chk("sclk_rises", 32'(rises[g]), 16);
                        chk("rdata", 32'(rdata_a[g]), 32'(e.rdata));
                        chk("cs_high_at_done", 32'(cs_a[g]), 1);
                    end
                end
                if (cs_a[g]) begin
                    if (!pcs[g]) begin
                        cs_rise_cyc[g] = cyc;
                        seen_rise[g]   = 1'b1;
                    end
                    bitcnt[g] = 0;
                    rises[g]  = 0;
                    miso_a[g] = 1'b0;
                end else begin
                    if (pcs[g]) begin
                        sh[g]  = 16'd0;
                        srw[g] = 1'b0;
                        if (seen_rise[g]) chk("cs_gap", 32'((cyc - cs_rise_cyc[g]) >= sp(g)), 1);
                    end
                    if (sclk_a[g] && !psclk[g]) begin
                        sh[g] = {sh[g][14:0], mosi_a[g]};
                        bitcnt[g]++;
                        rises[g]++;
                        if (bitcnt[g] == 1) first_rise[g] = cyc;
                        if (bitcnt[g] == 8) begin
                            saddr[g] = sh[g][7:1];
                            srw[g]   = sh[g][0];
                            sout[g]  = smem[g][sh[g][7:1]];
                        end
                        if (bitcnt[g] == 16 && !srw[g]) smem[g][saddr[g]] = sh[g][7:0];
                    end
                    if (!sclk_a[g] && psclk[g] && srw[g] && bitcnt[g] >= 8 && bitcnt[g] < 16)
                        miso_a[g] = sout[g][15 - bitcnt[g]];
                end
                psclk[g] = sclk_a[g];
                pcs[g]   = cs_a[g];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        int acc0;
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            start_a[g] = 1'b0; addr_a[g] = 7'd0; rw_a[g] = 1'b0; wdata_a[g] = 8'd0;
            last_rd[g] = 8'd0;
            for (int i = 0; i < 128; i++) begin
                logic [7:0] v;
                v = 8'($urandom);
                ref_mem[g][i] = v;
                smem[g][i]    = v;
            end
        end
        ref_mem[0][1] = 8'h5A;
        smem[0][1]    = 8'h5A;
        ref_mem[1][1] = 8'h5A;
        smem[1][1]    = 8'h5A;

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_busy", 32'(busy_a[g]), 0);
            chk("rst_done", 32'(done_a[g]), 0);
            chk("rst_rdata", 32'(rdata_a[g]), 0);
            chk("rst_sclk", 32'(sclk_a[g]), 0);
            chk("rst_cs", 32'(cs_a[g]), 1);
            chk("rst_mosi", 32'(mosi_a[g]), 0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        issue(0, 7'h2A, 1'b0, 8'hC3);
        wait_idle(0);
        issue(0, 7'h01, 1'b1, 8'hA7);
        wait_idle(0);

        // Starts at cycles 10 and 560 are ignored, the one at 561 is accepted
        issue(0, 7'h11, 1'b0, 8'h3C);
        acc0 = last_acc[0];
        repeat (9) @(negedge clk);
        chk("busy_at_10", 32'(busy_a[0]), 1);
        start_a[0] = 1'b1; addr_a[0] = 7'h22; rw_a[0] = 1'b0; wdata_a[0] = 8'h99;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (549) @(negedge clk);
        chk("busy_at_560", 32'(busy_a[0]), 1);
        start_a[0] = 1'b1; addr_a[0] = 7'h33; rw_a[0] = 1'b0; wdata_a[0] = 8'h66;
        @(negedge clk);
        start_a[0] = 1'b0;
        chk("accept_cycle", 32'(cyc - acc0), 561);
        issue(0, 7'h11, 1'b1, 8'h00);
        wait_idle(0);

        issue(0, 7'h7F, 1'b0, 8'hFF);
        wait_idle(0);
        issue(0, 7'h7F, 1'b1, 8'h12);
        wait_idle(0);

        for (int i = 0; i < 5; i++) begin
            issue(0, 7'($urandom_range(0, 7)), 1'($urandom), 8'($urandom));
            wait_idle(0);
        end

        issue(1, 7'h01, 1'b1, 8'h00);
        wait_idle(1);
        for (int i = 0; i < 12; i++) begin
            issue(1, 7'($urandom_range(0, 7)), 1'($urandom), 8'($urandom));
            wait_idle(1);
        end

        // Reset during SETUP abandons the frame and clears rdata
        issue(0, 7'h7F, 1'b1, 8'h00);
        wait_idle(0);
        start_a[0] = 1'b1; addr_a[0] = 7'h7F; rw_a[0] = 1'b0; wdata_a[0] = 8'h00;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_cs", 32'(cs_a[0]), 1);
        chk("midrst_sclk", 32'(sclk_a[0]), 0);
        chk("midrst_busy", 32'(busy_a[0]), 0);
        chk("midrst_rdata", 32'(rdata_a[0]), 0);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        repeat (S0 + 4) @(negedge clk);
        chk("postrst_cs", 32'(cs_a[0]), 1);
        issue(0, 7'h05, 1'b0, 8'h44);
        wait_idle(0);
        issue(0, 7'h7F, 1'b1, 8'h00);
        wait_idle(0);

        repeat (4) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
